// File: rtl/test_space.sv
// Event counter front-end: resynchronises async count/direction/clear levels
// and drives a registered up/down count with a one-cycle wrap pulse.
module test_space #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  output logic             y,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [WIDTH-1:0] CNT_MAX  = '1;

  logic [SYNC_STAGES-1:0] a_sync_q, a_sync_d;
  logic [SYNC_STAGES-1:0] b_sync_q, b_sync_d;
  logic [SYNC_STAGES-1:0] c_sync_q, c_sync_d;
  logic                   a_prev_q, a_prev_d;
  logic [WIDTH-1:0]       count_q, count_d;
  logic                   y_q, y_d;

  logic a_s, b_s, c_s, ev_s;

  // Bit 0 is the first synchroniser stage; the MSB feeds the counter logic.
  assign a_s  = a_sync_q[SYNC_STAGES-1];
  assign b_s  = b_sync_q[SYNC_STAGES-1];
  assign c_s  = c_sync_q[SYNC_STAGES-1];
  assign ev_s = a_s & ~a_prev_q;

  // Next-state: synchroniser shift, edge history, and clear > up > down > hold.
  always_comb begin
    a_sync_d = {a_sync_q[SYNC_STAGES-2:0], a};
    b_sync_d = {b_sync_q[SYNC_STAGES-2:0], b};
    c_sync_d = {c_sync_q[SYNC_STAGES-2:0], c};
    a_prev_d = a_s;
    count_d  = count_q;
    y_d      = 1'b0;
    if (c_s) begin
      count_d = CNT_ZERO;
      y_d     = 1'b0;
    end else if (ev_s && !b_s) begin
      count_d = count_q + CNT_ONE;
      y_d     = (count_q == CNT_MAX);
    end else if (ev_s && b_s) begin
      count_d = count_q - CNT_ONE;
      y_d     = (count_q == CNT_ZERO);
    end else begin
      count_d = count_q;
      y_d     = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sync_q <= '0;
      b_sync_q <= '0;
      c_sync_q <= '0;
      a_prev_q <= 1'b0;
      count_q  <= CNT_ZERO;
      y_q      <= 1'b0;
    end else begin
      a_sync_q <= a_sync_d;
      b_sync_q <= b_sync_d;
      c_sync_q <= c_sync_d;
      a_prev_q <= a_prev_d;
      count_q  <= count_d;
      y_q      <= y_d;
    end
  end

  assign y     = y_q;
  assign count = count_q;

endmodule

// File: tb/tb_test_space.sv
// Randomised and directed bench for test_space against a sample-history
// reference model (inputs take effect SYNC edges after being sampled).
module tb_test_space;
  localparam int WIDTH = 4;
  localparam int SYNC  = 2;
  localparam int MODV  = 1 << WIDTH;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             a     = 1'b0;
  logic             b     = 1'b0;
  logic             c     = 1'b0;
  logic             y;
  logic [WIDTH-1:0] count;

  int n_vec  = 0;
  int n_err  = 0;
  int y_seen = 0;

  int m_count;
  bit m_y;
  bit ah[$];
  bit bh[$];
  bit ch[$];

  test_space #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a),
    .b    (b),
    .c    (c),
    .y    (y),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_count = 0;
    m_y     = 1'b0;
    ah.delete(); bh.delete(); ch.delete();
    for (int i = 0; i <= SYNC; i++) begin
      ah.push_back(1'b0); bh.push_back(1'b0); ch.push_back(1'b0);
    end
  endtask

  // ah[0] is the sample from the previous edge; ah[SYNC-1] is the one acting now.
  task automatic model_edge(input bit ra, input bit rb, input bit rc, input bit rr);
    bit ae, ap, be, ce;
    if (!rr) begin
      model_reset();
    end else begin
      ae = ah[SYNC-1];
      ap = ah[SYNC];
      be = bh[SYNC-1];
      ce = ch[SYNC-1];
      if (ce) begin
        m_count = 0;
        m_y     = 1'b0;
      end else if (ae && !ap) begin
        if (!be) begin
          m_y     = (m_count == MODV - 1);
          m_count = (m_count + 1) % MODV;
        end else begin
          m_y     = (m_count == 0);
          m_count = (m_count + MODV - 1) % MODV;
        end
      end else begin
        m_y = 1'b0;
      end
      ah.push_front(ra); void'(ah.pop_back());
      bh.push_front(rb); void'(bh.pop_back());
      ch.push_front(rc); void'(ch.pop_back());
    end
  endtask

  task automatic cyc(input bit na, input bit nb, input bit nc, input bit nr, input string tag);
    @(negedge clk);
    a = na; b = nb; c = nc; rst_n = nr;
    @(posedge clk);
    model_edge(na, nb, nc, nr);
    #1;
    check_eq({tag, ".count"}, 32'(count), 32'(m_count));
    check_eq({tag, ".y"}, 32'(y), 32'(m_y));
    if (y === 1'b1) y_seen++;
  endtask

  task automatic pulses(input int n, input bit dir, input string tag);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, dir, 1'b0, 1'b1, tag);
      cyc(1'b1, dir, 1'b0, 1'b1, tag);
      cyc(1'b0, dir, 1'b0, 1'b1, tag);
      cyc(1'b0, dir, 1'b0, 1'b1, tag);
    end
  endtask

  initial begin
    bit ra, rb, rc, rr;
    int len;
    model_reset();

    // Reset with toggling inputs, then release idle.
    for (int i = 0; i < 3; i++) cyc(i[0], i[1], ~i[0], 1'b0, "rst");
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, "rst_idle");
    check_eq("rst_no_count", 32'(count), 32'd0);

    // Up count through wrap.
    y_seen = 0;
    pulses(16, 1'b0, "up");
    check_eq("up_wrap_count", 32'(count), 32'd0);
    check_eq("up_wrap_ypulses", 32'(y_seen), 32'd1);

    // Down count with underflow.
    y_seen = 0;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1, "dn_setup");
    pulses(2, 1'b1, "dn");
    check_eq("dn_count", 32'(count), 32'd14);
    check_eq("dn_ypulses", 32'(y_seen), 32'd1);

    // Clear priority at count 5.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1, "clr_pre");
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, "clr_pre");
    pulses(5, 1'b0, "clr_up");
    check_eq("clr_at5", 32'(count), 32'd5);
    y_seen = 0;
    cyc(1'b1, 1'b0, 1'b1, 1'b1, "clr");
    cyc(1'b1, 1'b0, 1'b1, 1'b1, "clr");
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1, "clr_hold");
    check_eq("clr_zero", 32'(count), 32'd0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, "clr_rel");
    pulses(1, 1'b0, "clr_resume");
    check_eq("clr_resume", 32'(count), 32'd1);
    check_eq("clr_ypulses", 32'(y_seen), 32'd0);

    // Sweep {a,b,c} from 000 to 111, starting from a freshly reset counter.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, "sw_rst");
    y_seen = 0;
    for (int code = 0; code < 8; code++)
      for (int j = 0; j < 20; j++)
        cyc(code[2], code[1], code[0], 1'b1, "sweep");
    check_eq("sweep_ypulses", 32'(y_seen), 32'd0);

    // Reset mid-count at 9, released with a held high.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, "mid_rst0");
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, "mid_idle");
    pulses(9, 1'b0, "mid_up");
    check_eq("mid_at9", 32'(count), 32'd9);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, "mid_rst");
    check_eq("mid_rst_zero", 32'(count), 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, "mid_rst");
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b0, 1'b1, "mid_rel");
    check_eq("mid_rel_one", 32'(count), 32'd1);

    // Random stimulus, each input value held 1-3 cycles.
    for (int i = 0; i < 400; i++) begin
      ra  = 1'($urandom_range(0, 1));
      rb  = 1'($urandom_range(0, 1));
      rc  = ($urandom_range(0, 7) == 0);
      rr  = ($urandom_range(0, 39) != 0);
      len = $urandom_range(1, 3);
      for (int j = 0; j < len; j++) cyc(ra, rb, rc, rr, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
